// File: rtl/fxp4s_qbuf_if.sv
// Handshake bundle between a producer, the fxp4s_qbuf result buffer and its consumer.
interface fxp4s_qbuf_if #(
    parameter int DEPTH = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [3:0]               in_q;
    logic                     in_dbz;
    logic                     out_valid;
    logic                     out_ready;
    logic [3:0]               out_data;
    logic                     out_dbz;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output in_valid, in_q, in_dbz, out_ready,
        input  in_ready, out_valid, out_data, out_dbz, count
    );

    modport slave (
        input  in_valid, in_q, in_dbz, out_ready,
        output in_ready, out_valid, out_data, out_dbz, count
    );
endinterface

// File: rtl/fxp4s_qbuf.sv
// FIFO buffer for 4-bit sign-magnitude divider results, converted to two's complement on push.
// Optional feature macro FXP4S_QBUF_DBZ_CNT_EN adds a saturating divide-by-zero push counter (dbz_cnt).
module fxp4s_qbuf #(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    fxp4s_qbuf_if.slave  bus
`ifdef FXP4S_QBUF_DBZ_CNT_EN
    ,
    output logic [7:0]   dbz_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Divide-by-zero saturates toward the dividend sign; negative zero collapses to 0.
    function automatic logic signed [3:0] f_sm_to_tc(input logic [3:0] q, input logic dbz);
        logic signed [3:0] mag;
        mag = $signed({1'b0, q[2:0]});
        if (dbz)
            f_sm_to_tc = q[3] ? -4'sd7 : 4'sd7;
        else if (q[2:0] == 3'd0)
            f_sm_to_tc = 4'sd0;
        else
            f_sm_to_tc = q[3] ? -mag : mag;
    endfunction

    logic [4:0]        r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic              w_push;
    logic              w_pop;
    logic              w_nonempty;
    logic signed [3:0] w_conv;

    assign w_nonempty = (r_count != '0);
    assign w_push     = bus.in_valid & (r_count != FULL);
    assign w_pop      = bus.out_ready & w_nonempty;
    assign w_conv     = f_sm_to_tc(bus.in_q, bus.in_dbz);

    assign bus.in_ready  = (r_count != FULL);
    assign bus.out_valid = w_nonempty;
    assign bus.out_data  = w_nonempty ? r_mem[r_rptr][3:0] : 4'd0;
    assign bus.out_dbz   = w_nonempty ? r_mem[r_rptr][4]   : 1'b0;
    assign bus.count     = r_count;

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= {bus.in_dbz, w_conv};
    end

    // Power-of-two depth: pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef FXP4S_QBUF_DBZ_CNT_EN
    logic [7:0] r_dbz_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_dbz_cnt <= '0;
        else if (w_push && bus.in_dbz && (r_dbz_cnt != 8'hFF))
            r_dbz_cnt <= r_dbz_cnt + 1'b1;
    end

    assign dbz_cnt = r_dbz_cnt;
`endif
endmodule

// File: doc/fxp4s_qbuf.md
FXP4S_QBUF -- requirements
Module: fxp4s_qbuf

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of FIFO entries; legal values are 2, 4 and 8 (power of two).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  a divider result is presented.
REQ-005 SHALL have port in_ready  output  1  the buffer can accept a result this cycle.
REQ-006 SHALL have port in_q  input  4  divider quotient in sign-magnitude form: bit 3 is the sign, bits 2:0 are the magnitude.
REQ-007 SHALL have port in_dbz  input  1  divide-by-zero flag belonging to in_q.
REQ-008 SHALL have port out_valid  output  1  the head entry is available.
REQ-009 SHALL have port out_ready  input  1  the consumer accepts the head entry.
REQ-010 SHALL have port out_data  output  4  head quotient in two's complement.
REQ-011 SHALL have port out_dbz  output  1  divide-by-zero flag of the head entry.
REQ-012 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-013 Push SHALL occur on a rising edge where in_valid=1 and in_ready=1; pop SHALL occur on a rising edge where out_valid=1 and out_ready=1.
REQ-014 in_ready SHALL be (count<DEPTH) and SHALL depend only on registered state, never on out_ready.
REQ-015 out_valid SHALL be (count!=0), driven from registered state.
REQ-016 Conversion SHALL be applied at push time, with the following rules:
  - in_dbz=1: store the saturated value, +7 (0111) if in_q[3]=0 or -7 (1001) if in_q[3]=1.
  - in_dbz=0 and magnitude 0: store 0000, so negative zero is normalised.
  - otherwise: store sign ? -magnitude : +magnitude, in 4-bit two's complement.
REQ-017 in_dbz SHALL be stored alongside the data and presented on out_dbz.
REQ-018 Order SHALL be strictly FIFO, and write and read pointers SHALL wrap modulo DEPTH.
REQ-019 Latency SHALL be one cycle: an entry pushed at edge k is presented on out_data, with out_valid=1, after edge k; there is no combinational bypass when empty.
REQ-020 When empty, out_data and out_dbz SHALL read 0.
REQ-021 A simultaneous push and pop when 0<count<DEPTH SHALL leave count unchanged and both transfers SHALL complete.
REQ-022 When full, in_ready=0. A pop in the full state SHALL reduce count to DEPTH-1, and in_ready SHALL rise in the following cycle.
REQ-023 When empty, a pop attempt (out_ready=1) SHALL have no effect.
REQ-024 in_q and in_dbz SHALL be ignored whenever no push occurs.

Reset
REQ-025 Assertion of rst SHALL immediately, without waiting for clk, clear both pointers and count.
REQ-026 During reset the outputs SHALL be out_valid=0, out_data=0, out_dbz=0, count=0, in_ready=1.
REQ-027 Reset mid-operation SHALL discard all stored entries; the first push after deassertion SHALL be the first entry popped.
REQ-028 Storage array contents need not be reset; REQ-020 masks them.

Configuration
REQ-029 Macro FXP4S_QBUF_DBZ_CNT_EN SHALL, when defined, add output port dbz_cnt  output  8, behaving as follows:
  - increments on each push with in_dbz=1;
  - saturates at 255;
  - clears on rst.
REQ-030 When FXP4S_QBUF_DBZ_CNT_EN is undefined, dbz_cnt and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Reset, then push in_q=1011 (-3), in_dbz=0 -> after one edge, out_valid=1, out_data=1101, out_dbz=0, count=1.
REQ-032 Push in_q=1000 (-0), then push in_q=0101 with in_dbz=1 -> pops in order return 0000/dbz=0, then 0111/dbz=1.
REQ-033 DEPTH=4, out_ready=0, push 5 values -> in_ready=0 after the 4th; the 5th is not accepted; count=4. Raise out_ready for one cycle -> count=3, and in_ready=1 next cycle.
REQ-034 count=2, in_valid=1 and out_ready=1 held for 6 cycles -> count stays 2; output order equals input order across pointer wrap.
REQ-035 count=3, assert rst asynchronously between edges -> out_valid=0 and count=0 before the next edge; after release, a push of 0010 pops as 0010.
REQ-036 With FXP4S_QBUF_DBZ_CNT_EN defined, 260 pushes with in_dbz=1 (consumer always ready) -> dbz_cnt=255; after rst, dbz_cnt=0.
